// File: rtl/adjacency_map.sv
// -----------------------------------------------------------------------------
// adjacency_map
//
// Purpose
//   Builds a compressed adjacency list while a decoder streams source nodes and
//   their out-edges (LOAD), then serves queries that return every destination
//   of a node, one beat per edge, in the order the edges were loaded.
//
//   Storage:
//     edge_mem   - destination node per edge slot, written sequentially
//     start_tbl  - first edge slot of each source node
//     cnt_tbl    - number of edges of each source node
//     node_valid - node has been registered as a source since reset
//
// Optional feature
//   Define ADJACENCY_MAP_OVERFLOW_FLAG_EN to get the edge_overflow output, a
//   sticky flag that rises the cycle after the first edge is dropped because
//   edge storage is full. Without the macro, dropped edges are silent.
//
// Ports
//   clk                  in   single clock, rising edge
//   rst                  in   asynchronous active-high reset
//   decoding_done        in   end of edge load (pulse or level)
//   src_node_valid       in   new source node on src_node
//   edge_valid           in   edge src_node -> dst_node present
//   src_node             in   source node index
//   dst_node             in   destination node index
//   node_idx_cnt         in   number of distinct nodes (captured with decoding_done)
//   query_ready          out  block accepts a query (IDLE only)
//   query_valid          in   query request
//   query_data           in   node whose out-edges are requested
//   reply_ready          in   consumer accepts current reply beat
//   reply_valid          out  reply beat present
//   reply_last           out  final beat of the reply
//   reply_data           out  destination node of one out-edge
//   reply_no_edges_found out  queried node has no out-edges (single beat)
//   edge_overflow        out  sticky drop flag (only with the macro above)
// -----------------------------------------------------------------------------
module adjacency_map #(
    parameter int MAX_NODES  = 1024,
    parameter int NODE_WIDTH = $clog2(MAX_NODES),
    parameter int MAX_EDGES  = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  decoding_done,
    input  logic                  src_node_valid,
    input  logic                  edge_valid,
    input  logic [NODE_WIDTH-1:0] src_node,
    input  logic [NODE_WIDTH-1:0] dst_node,
    input  logic [NODE_WIDTH-1:0] node_idx_cnt,
    output logic                  query_ready,
    input  logic                  query_valid,
    input  logic [NODE_WIDTH-1:0] query_data,
    input  logic                  reply_ready,
    output logic                  reply_valid,
    output logic                  reply_last,
    output logic [NODE_WIDTH-1:0] reply_data,
    output logic                  reply_no_edges_found
`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
    ,
    output logic                  edge_overflow
`endif
);

    localparam int AW    = $clog2(MAX_EDGES);
    localparam int PTR_W = AW + 1;
    localparam int CNT_W = (NODE_WIDTH + 1 > PTR_W) ? NODE_WIDTH + 1 : PTR_W;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        IDLE   = 2'd1,
        LOOKUP = 2'd2,
        STREAM = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Control state (asynchronously reset)
    logic [PTR_W-1:0]      wr_ptr;
    logic [MAX_NODES-1:0]  node_valid;
    logic [NODE_WIDTH-1:0] idx_cnt;

    // Table storage (no reset; contents are qualified by node_valid)
    logic [NODE_WIDTH-1:0] edge_mem  [MAX_EDGES];
    logic [PTR_W-1:0]      start_tbl [MAX_NODES];
    logic [CNT_W-1:0]      cnt_tbl   [MAX_NODES];

    // Query pipeline: p0 = accepted query, p1 = table read result
    logic [NODE_WIDTH-1:0] query_p0;
    logic [PTR_W-1:0]      rd_ptr_p1;
    logic [CNT_W-1:0]      rd_left_p1;
    logic                  empty_p1;

    logic load_active;
    logic ptr_full;
    logic edge_accept;
    logic beat_done;

    assign load_active = (state == LOAD);
    assign ptr_full    = (wr_ptr == PTR_W'(MAX_EDGES));
    assign edge_accept = load_active && edge_valid && !ptr_full;

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (decoding_done) state_next = IDLE;
            IDLE:    if (query_valid) state_next = LOOKUP;
            LOOKUP:  state_next = STREAM;
            STREAM:  if (reply_ready && reply_last) state_next = IDLE;
            default: state_next = LOAD;
        endcase
    end

    // -------------------------------------------------------------------------
    // Load control: write pointer, node valid bits, captured node count
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            node_valid <= '0;
            idx_cnt    <= '0;
        end else if (load_active) begin
            if (src_node_valid) begin
                node_valid[src_node] <= 1'b1;
            end
            if (edge_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (decoding_done) begin
                idx_cnt <= node_idx_cnt;
            end
        end
    end

`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
    logic edge_drop;
    assign edge_drop = load_active && edge_valid && ptr_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_overflow <= 1'b0;
        end else if (edge_drop) begin
            edge_overflow <= 1'b1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Table writes. Registration wins over a coincident edge so that the edge
    // is counted against the new source (count starts at 1, not 0).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (load_active && src_node_valid) begin
            start_tbl[src_node] <= wr_ptr;
            cnt_tbl[src_node]   <= edge_accept ? CNT_W'(1) : '0;
        end else if (edge_accept) begin
            cnt_tbl[src_node]   <= cnt_tbl[src_node] + 1'b1;
        end
        if (edge_accept) begin
            edge_mem[wr_ptr[AW-1:0]] <= dst_node;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p0: capture accepted query
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (query_ready && query_valid) begin
            query_p0 <= query_data;
        end
    end

    // -------------------------------------------------------------------------
    // Stage p1: table read in LOOKUP, then walk the edge list in STREAM
    // -------------------------------------------------------------------------
    assign beat_done = reply_valid && reply_ready;

    always_ff @(posedge clk) begin
        if (state == LOOKUP) begin
            rd_ptr_p1  <= start_tbl[query_p0];
            rd_left_p1 <= cnt_tbl[query_p0];
            empty_p1   <= !node_valid[query_p0] ||
                          (cnt_tbl[query_p0] == '0) ||
                          (query_p0 >= idx_cnt);
        end else if (beat_done && !reply_last) begin
            rd_ptr_p1  <= rd_ptr_p1 + 1'b1;
            rd_left_p1 <= rd_left_p1 - 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs are decoded from state, so reset clears them immediately and a
    // stalled beat holds because neither the pointer nor the memory changes.
    // -------------------------------------------------------------------------
    always_comb begin
        query_ready          = (state == IDLE);
        reply_valid          = (state == STREAM);
        reply_no_edges_found = (state == STREAM) && empty_p1;
        reply_last           = (state == STREAM) &&
                               (empty_p1 || (rd_left_p1 == CNT_W'(1)));
        reply_data           = '0;
        // Range guard keeps a corrupt pointer from aliasing into the memory.
        if ((state == STREAM) && !empty_p1 && (rd_ptr_p1 < PTR_W'(MAX_EDGES))) begin
            reply_data = edge_mem[rd_ptr_p1[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_adjacency_map.sv
module tb_adjacency_map;

    localparam int MN = 16;
    localparam int NW = 4;
    localparam int ME = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          decoding_done;
    logic          src_node_valid;
    logic          edge_valid;
    logic [NW-1:0] src_node;
    logic [NW-1:0] dst_node;
    logic [NW-1:0] node_idx_cnt;
    logic          query_ready;
    logic          query_valid;
    logic [NW-1:0] query_data;
    logic          reply_ready;
    logic          reply_valid;
    logic          reply_last;
    logic [NW-1:0] reply_data;
    logic          reply_no_edges_found;
`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
    logic          edge_overflow;
`endif

    adjacency_map #(
        .MAX_NODES (MN),
        .NODE_WIDTH(NW),
        .MAX_EDGES (ME)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .decoding_done       (decoding_done),
        .src_node_valid      (src_node_valid),
        .edge_valid          (edge_valid),
        .src_node            (src_node),
        .dst_node            (dst_node),
        .node_idx_cnt        (node_idx_cnt),
        .query_ready         (query_ready),
        .query_valid         (query_valid),
        .query_data          (query_data),
        .reply_ready         (reply_ready),
        .reply_valid         (reply_valid),
        .reply_last          (reply_last),
        .reply_data          (reply_data),
        .reply_no_edges_found(reply_no_edges_found)
`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
        ,
        .edge_overflow       (edge_overflow)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-node list of destinations, global count of stored edges.
    int model [MN][$];
    int total_edges;
    int idx_cnt_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge(input int n, input int d);
        if (total_edges < ME) begin
            model[n].push_back(d);
            total_edges++;
        end
    endtask

    task automatic reg_src(input int n, input bit with_edge, input int d);
        src_node       = NW'(n);
        dst_node       = NW'(d);
        src_node_valid = 1'b1;
        edge_valid     = with_edge;
        model[n].delete();
        if (with_edge) model_edge(n, d);
        step();
        src_node_valid = 1'b0;
        edge_valid     = 1'b0;
    endtask

    task automatic add_edge(input int n, input int d);
        src_node   = NW'(n);
        dst_node   = NW'(d);
        edge_valid = 1'b1;
        model_edge(n, d);
        step();
        edge_valid = 1'b0;
    endtask

    task automatic finish_load();
        decoding_done = 1'b1;
        step();
        decoding_done = 1'b0;
        chk("ready_after_done", query_ready, 1);
    endtask

    // Issue one query and check the whole reply. stall_beat < 0 means no stall.
    task automatic do_query(input int q, input int stall_beat, input int stall_len);
        int  exp_d[$];
        bit  empty;
        int  n;
        empty = (q >= idx_cnt_m) || (model[q].size() == 0);
        if (empty) exp_d.push_back(0);
        else exp_d = model[q];
        n = exp_d.size();

        chk($sformatf("q%0d_ready", q), query_ready, 1);
        if (query_ready !== 1'b1) return;
        query_valid = 1'b1;
        query_data  = NW'(q);
        step();
        query_valid = 1'b0;
        chk($sformatf("q%0d_lookup_no_valid", q), reply_valid, 0);
        step();
        for (int b = 0; b < n; b++) begin
            if (b == stall_beat) begin
                reply_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk($sformatf("q%0d_stall%0d_valid", q, s), reply_valid, 1);
                    chk($sformatf("q%0d_stall%0d_data", q, s), reply_data, exp_d[b]);
                    chk($sformatf("q%0d_stall%0d_last", q, s), reply_last, (b == n - 1));
                    step();
                end
            end
            reply_ready = 1'b1;
            chk($sformatf("q%0d_b%0d_valid", q, b), reply_valid, 1);
            chk($sformatf("q%0d_b%0d_data", q, b), reply_data, exp_d[b]);
            chk($sformatf("q%0d_b%0d_last", q, b), reply_last, (b == n - 1));
            chk($sformatf("q%0d_b%0d_noedge", q, b), reply_no_edges_found, empty);
            step();
        end
        reply_ready = 1'b0;
        chk($sformatf("q%0d_done_ready", q), query_ready, 1);
        chk($sformatf("q%0d_done_valid", q), reply_valid, 0);
    endtask

    initial begin
        rst            = 1'b1;
        decoding_done  = 1'b0;
        src_node_valid = 1'b0;
        edge_valid     = 1'b0;
        src_node       = '0;
        dst_node       = '0;
        node_idx_cnt   = '0;
        query_valid    = 1'b0;
        query_data     = '0;
        reply_ready    = 1'b0;
        total_edges    = 0;
        idx_cnt_m      = 10;

        #2;
        chk("rst_query_ready", query_ready, 0);
        chk("rst_reply_valid", reply_valid, 0);
        chk("rst_reply_last", reply_last, 0);
        chk("rst_reply_data", reply_data, 0);
        chk("rst_no_edges", reply_no_edges_found, 0);
`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
        chk("rst_overflow", edge_overflow, 0);
`endif
        step();
        step();
        rst = 1'b0;

        // Queries before decoding_done must not be accepted.
        query_valid = 1'b1;
        query_data  = 4'd3;
        for (int i = 0; i < 3; i++) begin
            chk("load_query_ready", query_ready, 0);
            chk("load_reply_valid", reply_valid, 0);
            step();
        end
        query_valid = 1'b0;

        node_idx_cnt = 4'd10;
        reg_src(3, 1'b0, 0);
        add_edge(3, 5);
        add_edge(3, 7);
        add_edge(3, 9);
        reg_src(1, 1'b0, 0);
        add_edge(1, int'($urandom_range(0, 15)));
        add_edge(1, int'($urandom_range(0, 15)));
        reg_src(1, 1'b0, 0);                          // overwrite node 1
        for (int i = 0; i < 3; i++) add_edge(1, int'($urandom_range(0, 15)));
        reg_src(0, 1'b1, int'($urandom_range(0, 15))); // coincident first edge
        add_edge(0, int'($urandom_range(0, 15)));
        reg_src(2, 1'b0, 0);                          // registered, no edges
        reg_src(12, 1'b0, 0);                         // beyond node_idx_cnt
        add_edge(12, 4);
        chk("load_still_not_ready", query_ready, 0);
        finish_load();

        do_query(3, -1, 0);
        do_query(5, -1, 0);
        do_query(3, 1, 4);
        do_query(0, -1, 0);
        do_query(1, 2, 2);
        do_query(2, -1, 0);
        do_query(12, -1, 0);
        for (int i = 0; i < 6; i++) begin
            int q;
            q = int'($urandom_range(0, 15));
            do_query(q, int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        // Load inputs outside LOAD are ignored.
        src_node       = 4'd3;
        dst_node       = 4'd1;
        src_node_valid = 1'b1;
        edge_valid     = 1'b1;
        step();
        src_node_valid = 1'b0;
        edge_valid     = 1'b0;
        do_query(3, -1, 0);

        // Reset in the middle of a 3-beat reply.
        query_valid = 1'b1;
        query_data  = 4'd3;
        step();
        query_valid = 1'b0;
        step();
        reply_ready = 1'b1;
        step();
        chk("abort_pre_valid", reply_valid, 1);
        chk("abort_pre_data", reply_data, 7);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", reply_valid, 0);
        chk("abort_data", reply_data, 0);
        chk("abort_last", reply_last, 0);
        chk("abort_ready", query_ready, 0);
        reply_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int n = 0; n < MN; n++) model[n].delete();
        total_edges = 0;
        chk("abort_still_load", query_ready, 0);
        chk("abort_no_beats", reply_valid, 0);

        // Reload with more edges than storage holds.
        reg_src(4, 1'b1, int'($urandom_range(0, 15)));
        for (int i = 0; i < ME + 1; i++) add_edge(4, int'($urandom_range(0, 15)));
        finish_load();
        chk("overflow_model_total", total_edges, ME);
`ifdef ADJACENCY_MAP_OVERFLOW_FLAG_EN
        chk("overflow_flag", edge_overflow, 1);
`endif
        do_query(4, ME - 1, 2);
        do_query(3, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
